muldiv_issue_ctrl: RTL and testbench

// - Issue controller for the shared multi-cycle multiply/divide unit in the OOO execute stage.
// - Arbitrates NUM_REQ reservation-station requesters (decoded mult/div ops) onto one non-pipelined

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_issue_ctrl_rr_arbiter.sv | 68 ++++++
 rtl/muldiv_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and latency defaults for the mult/div issue controller.
// Arbitration mode is selected with MULDIV_RR_EN (see rr_arbiter).
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } muldiv_op_t;

   localparam int MULT_LAT_DEF = 3;
   localparam int DIV_LAT_DEF  = 16;

   function automatic int lat_max(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_rr_arbiter.sv
// One-hot grant among NUM_REQ requesters. MULDIV_RR_EN defined: round-robin
// from a rotating pointer; undefined: fixed priority, lowest index wins.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   input  logic               advance
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic w_found;

`ifdef MULDIV_RR_EN
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_next_ptr;
   logic [PTR_W-1:0] w_idx;
   logic [PTR_W:0]   w_sum;

   // Walk the requesters starting at the pointer, wrapping at NUM_REQ.
   always_comb begin
      grant      = '0;
      w_found    = 1'b0;
      w_next_ptr = r_ptr;
      w_idx      = '0;
      w_sum      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
         if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
         end
         w_idx = w_sum[PTR_W-1:0];
         if (en && !w_found && req[w_idx]) begin
            w_found      = 1'b1;
            grant[w_idx] = 1'b1;
            w_next_ptr   = (w_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (advance) begin
         r_ptr <= w_next_ptr;
      end
   end
`else
   logic w_unused;
   assign w_unused = &{1'b0, clk, reset, advance};

   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (en && !w_found && req[k]) begin
            w_found  = 1'b1;
            grant[k] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the shared non-pipelined mult/div unit: arbitrates
// reservation stations, sequences the unit, holds the result for the CDB. Uses MULDIV_RR_EN.
//
// state | meaning
// IDLE  | no op in flight; grants allowed when not flushing
// BUSY  | unit running; counter tracks remaining latency
// DONE  | result held on the CDB until cdb_ready
module muldiv_issue_ctrl
   import muldiv_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = 64,
   parameter int TAG_W    = 4,
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_div,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   output logic                      fu_start,
   output logic                      fu_mult,
   output logic                      fu_div,
   output logic [DATA_W-1:0]         fu_a,
   output logic [DATA_W-1:0]         fu_b,
   input  logic [DATA_W-1:0]         fu_result,
   output logic                      cdb_valid,
   input  logic                      cdb_ready,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data,
   output logic                      busy
);

   localparam int CNT_W = $clog2(lat_max(MULT_LAT, DIV_LAT)) + 1;
   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

   muldiv_state_t     r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [TAG_W-1:0]  r_tag;
   logic              r_fu_start;
   logic              r_fu_mult;
   logic              r_fu_div;
   logic [DATA_W-1:0] r_fu_a;
   logic [DATA_W-1:0] r_fu_b;
   logic              r_cdb_valid;
   logic [TAG_W-1:0]  r_cdb_tag;
   logic [DATA_W-1:0] r_cdb_data;

   logic               w_arb_en;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_accept;
   muldiv_op_t         w_sel_op;
   logic [DATA_W-1:0]  w_sel_a;
   logic [DATA_W-1:0]  w_sel_b;
   logic [TAG_W-1:0]   w_sel_tag;
   logic               w_div_zero;

   assign w_arb_en = (r_state == IDLE) && !flush;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .en      (w_arb_en),
      .grant   (w_grant),
      .advance (w_accept)
   );

   assign req_ready = w_grant;
   assign w_accept  = |(req_valid & w_grant);

   // Grant is one-hot, so an OR-style select picks the winner's payload.
   always_comb begin
      w_sel_op  = OP_MULT;
      w_sel_a   = '0;
      w_sel_b   = '0;
      w_sel_tag = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_op  = req_div[i] ? OP_DIV : OP_MULT;
            w_sel_a   = req_a[i*DATA_W +: DATA_W];
            w_sel_b   = req_b[i*DATA_W +: DATA_W];
            w_sel_tag = req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   assign w_div_zero = (w_sel_op == OP_DIV) && (w_sel_b == '0);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_tag       <= '0;
         r_fu_start  <= 1'b0;
         r_fu_mult   <= 1'b0;
         r_fu_div    <= 1'b0;
         r_fu_a      <= '0;
         r_fu_b      <= '0;
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_div_zero) begin
                     // Unsigned divide by zero returns 0 without touching the unit.
                     r_state     <= DONE;
                     r_cdb_valid <= 1'b1;
                     r_cdb_tag   <= w_sel_tag;
                     r_cdb_data  <= '0;
                  end else begin
                     r_state    <= BUSY;
                     r_tag      <= w_sel_tag;
                     r_fu_start <= 1'b1;
                     r_fu_mult  <= (w_sel_op == OP_MULT);
                     r_fu_div   <= (w_sel_op == OP_DIV);
                     r_fu_a     <= w_sel_a;
                     r_fu_b     <= w_sel_b;
                     r_cnt      <= (w_sel_op == OP_DIV) ? DIV_CNT : MULT_CNT;
                  end
               end
            end
            BUSY: begin
               r_fu_start <= 1'b0;
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= DONE;
                  r_cdb_valid <= 1'b1;
                  r_cdb_tag   <= r_tag;
                  r_cdb_data  <= fu_result;
                  r_fu_mult   <= 1'b0;
                  r_fu_div    <= 1'b0;
                  r_fu_a      <= '0;
                  r_fu_b      <= '0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               if (cdb_ready) begin
                  r_state     <= IDLE;
                  r_cdb_valid <= 1'b0;
                  r_cdb_tag   <= '0;
                  r_cdb_data  <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign fu_start  = r_fu_start;
   assign fu_mult   = r_fu_mult;
   assign fu_div    = r_fu_div;
   assign fu_a      = r_fu_a;
   assign fu_b      = r_fu_b;
   assign cdb_valid = r_cdb_valid;
   assign cdb_tag   = r_cdb_tag;
   assign cdb_data  = r_cdb_data;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl: directed vector table, flush/reset
// and contention sequences, then randomized traffic against a transaction-level model.
module tb_muldiv_issue_ctrl;

   localparam int NUM_REQ  = 2;
   localparam int DATA_W   = 64;
   localparam int TAG_W    = 4;
   localparam int MULT_LAT = 3;
   localparam int DIV_LAT  = 16;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      flush;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_div;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [NUM_REQ*TAG_W-1:0]  req_tag;
   logic                      fu_start;
   logic                      fu_mult;
   logic                      fu_div;
   logic [DATA_W-1:0]         fu_a;
   logic [DATA_W-1:0]         fu_b;
   logic [DATA_W-1:0]         fu_result;
   logic                      cdb_valid;
   logic                      cdb_ready;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_data;
   logic                      busy;

   muldiv_issue_ctrl #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W),
      .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_div(req_div),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .fu_start(fu_start), .fu_mult(fu_mult), .fu_div(fu_div),
      .fu_a(fu_a), .fu_b(fu_b), .fu_result(fu_result),
      .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // External unit: result is correct only in the cycle the controller must sample it.
   int                u_age = 0;
   int                w_age;
   int                w_lat;
   logic [DATA_W-1:0] w_good;
   always @(posedge clk) u_age <= fu_start ? 1 : u_age + 1;
   always_comb begin
      w_age  = fu_start ? 0 : u_age;
      w_lat  = fu_div ? DIV_LAT : MULT_LAT;
      w_good = fu_div ? ((fu_b != 0) ? fu_a / fu_b : '0) : fu_a * fu_b;
      fu_result = ((fu_mult || fu_div) && (w_age == w_lat - 1)) ? w_good : ~w_good;
   end

   int n_cmp = 0;
   int n_err = 0;
   int m_ptr = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] v, input int ptr);
      logic [NUM_REQ-1:0] g;
      int idx;
      g = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MULDIV_RR_EN
         idx = (ptr + k) % NUM_REQ;
`else
         idx = k + (ptr & 0);
`endif
         if (v[idx]) begin
            g[idx] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
      for (int k = 0; k < NUM_REQ; k++) if (g[k]) return k;
      return -1;
   endfunction

   function automatic logic [63:0] ref_result(input bit d, input logic [63:0] a, input logic [63:0] b);
      if (d) return (b == 0) ? 64'd0 : a / b;
      return a * b;
   endfunction

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; req_valid = '0; req_div = '0;
      req_a = '0; req_b = '0; req_tag = '0; cdb_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
   endtask

   // Present one op on requester idx alone; returns at the first negedge after accept.
   task automatic start_op(input int idx, input bit d, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] tg);
      @(negedge clk);
      req_valid = '0;
      req_valid[idx] = 1'b1;
      req_div[idx] = d;
      req_a[idx*DATA_W +: DATA_W] = a;
      req_b[idx*DATA_W +: DATA_W] = b;
      req_tag[idx*TAG_W +: TAG_W] = tg;
      #1 check("grant_single", req_ready, 64'(1 << idx));
      if (req_ready[idx]) m_ptr = (idx + 1) % NUM_REQ;
      @(negedge clk);
      req_valid = '0;
   endtask

   typedef struct {
      int          idx;
      bit          div;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  tag;
      int          bp;
      logic [63:0] exp_data;
      int          exp_lat;
      int          exp_start;
      int          exp_hold;
   } vec_t;

   task automatic run_txn(input vec_t t);
      int lat, starts, holds;
      logic [TAG_W-1:0]  tg;
      logic [DATA_W-1:0] dt;
      start_op(t.idx, t.div, t.a, t.b, t.tag);
      lat = 0; starts = 0; holds = 0;
      for (int c = 1; c <= DIV_LAT + 6; c++) begin
         #1;
         if (cdb_valid) begin
            lat = c;
            break;
         end
         starts += int'(fu_start);
         holds  += int'(t.div ? fu_div : fu_mult);
         @(negedge clk);
      end
      check("txn_latency", 64'(lat), 64'(t.exp_lat));
      check("txn_data", cdb_data, t.exp_data);
      check("txn_tag", 64'(cdb_tag), 64'(t.tag));
      check("txn_fu_start_cnt", 64'(starts), 64'(t.exp_start));
      check("txn_fu_op_hold", 64'(holds), 64'(t.exp_hold));
      tg = cdb_tag; dt = cdb_data;
      for (int k = 0; k < t.bp; k++) begin
         @(negedge clk);
         req_valid = '1;
         #1;
         check("bp_valid", 64'(cdb_valid), 64'd1);
         check("bp_tag_stable", 64'(cdb_tag), 64'(tg));
         check("bp_data_stable", cdb_data, dt);
         check("bp_no_grant", 64'(req_ready), 64'd0);
      end
      cdb_ready = 1'b1;
      @(negedge clk);
      cdb_ready = 1'b0;
      #1;
      check("post_hs_cdb_valid", 64'(cdb_valid), 64'd0);
      check("post_hs_busy", 64'(busy), 64'd0);
      if (t.bp > 0) check("post_hs_grant", 64'(req_ready), 64'(pick('1, m_ptr)));
      req_valid = '0;
   endtask

   vec_t vecs[6];
   int   nv;
   int   multi, bad;
   int   grants[$];
   int   exp_seq[4];

   // Randomized-phase model state
   logic [NUM_REQ-1:0] pend;
   bit                 pdiv[NUM_REQ];
   logic [63:0]        pa[NUM_REQ];
   logic [63:0]        pb[NUM_REQ];
   logic [3:0]         ptag[NUM_REQ];
   bit                 m_inflight;
   int                 m_valid_at, m_free_at, cyc, gi;
   logic [3:0]         m_tag;
   logic [63:0]        m_data;
   logic [NUM_REQ-1:0] exp_rdy;
   bit                 exp_v;

   initial begin
      vecs[0] = '{0, 1'b0, 64'd7, 64'd6, 4'd3, 0, 64'd42, 4, 1, 3};
      vecs[1] = '{1, 1'b1, 64'd100, 64'd7, 4'd5, 0, 64'd14, 17, 1, 16};
      vecs[2] = '{0, 1'b1, 64'd5, 64'd0, 4'd7, 0, 64'd0, 1, 0, 0};
      vecs[3] = '{1, 1'b0, 64'h1_0000_0001, 64'h10, 4'd12, 5, 64'h10_0000_0010, 4, 1, 3};
      vecs[4] = '{0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 4'd1, 2, 64'h5555_5555_5555_5555, 17, 1, 16};
      vecs[5] = '{1, 1'b0, 64'd0, 64'd12345, 4'd15, 0, 64'd0, 4, 1, 3};

      do_reset();
      @(negedge clk); #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      check("rst_fu_start", 64'(fu_start), 64'd0);
      check("rst_fu_op", 64'({fu_mult, fu_div}), 64'd0);
      check("rst_fu_a", fu_a, 64'd0);
      check("rst_cdb_data", cdb_data, 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);

      for (int v = 0; v < 6; v++) run_txn(vecs[v]);

      // Flush in the second BUSY cycle of a divide.
      start_op(1, 1'b1, 64'd100, 64'd7, 4'd9);
      #1 check("flush_seq_start", 64'(fu_start), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      #1 check("flush_no_grant", 64'(req_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_fu_div", 64'(fu_div), 64'd0);
      check("flush_fu_a", fu_a, 64'd0);
      nv = 0;
      repeat (20) begin @(negedge clk); #1; if (cdb_valid) nv++; end
      check("flush_no_cdb", 64'(nv), 64'd0);
      run_txn(vecs[1]);

      // Flush wins over a simultaneous CDB handshake and over a request handshake.
      start_op(0, 1'b1, 64'd5, 64'd0, 4'd2);
      flush = 1'b1; cdb_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; cdb_ready = 1'b0;
      #1 check("flush_done_drop", 64'(cdb_valid), 64'd0);
      @(negedge clk);
      req_valid = 2'b01; flush = 1'b1;
      #1 check("flush_blocks_grant", 64'(req_ready), 64'd0);
      @(negedge clk);
      req_valid = '0; flush = 1'b0;
      #1 check("flush_no_accept", 64'(busy), 64'd0);

      // Reset in the middle of a multiply.
      start_op(0, 1'b0, 64'd7, 64'd6, 4'd3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; m_ptr = 0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_fu_mult", 64'(fu_mult), 64'd0);
      nv = 0;
      repeat (8) begin @(negedge clk); #1; if (cdb_valid) nv++; end
      check("midrst_no_cdb", 64'(nv), 64'd0);
      run_txn(vecs[0]);

      // Contention: both requesters valid continuously.
      do_reset();
      req_valid = '1; req_div = '0; req_a = {64'd2, 64'd3}; req_b = {64'd4, 64'd5};
      cdb_ready = 1'b1;
      multi = 0; bad = 0; grants.delete();
      for (int c = 0; c < 80 && grants.size() < 4; c++) begin
         @(negedge clk); #1;
         if ($countones(req_ready) > 1) multi++;
         if (busy && req_ready != 0) bad++;
         if (req_ready != 0) grants.push_back(onehot_idx(req_ready));
      end
      req_valid = '0;
`ifdef MULDIV_RR_EN
      exp_seq = '{0, 1, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0};
`endif
      check("cont_grant_count", 64'(grants.size()), 64'd4);
      for (int g = 0; g < 4; g++)
         check("cont_grant_order", 64'((g < grants.size()) ? grants[g] : -1), 64'(exp_seq[g]));
      check("cont_multi_grant", 64'(multi), 64'd0);
      check("cont_grant_when_busy", 64'(bad), 64'd0);
      for (int c = 0; c < 30 && busy; c++) begin @(negedge clk); #1; end
      check("cont_drain", 64'(busy), 64'd0);
      cdb_ready = 1'b0;

      // Randomized traffic against a transaction-level model.
      do_reset();
      pend = '0; m_inflight = 0; m_free_at = 0; cyc = 0; m_tag = '0; m_data = '0; m_valid_at = 0;
      for (int i = 0; i < NUM_REQ; i++) begin pdiv[i] = 0; pa[i] = '0; pb[i] = '0; ptag[i] = '0; end
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               pdiv[i] = 1'($urandom_range(1));
               pa[i]   = {$urandom, $urandom};
               pb[i]   = ($urandom_range(5) == 0) ? 64'd0 :
                         ($urandom_range(1) == 0) ? 64'($urandom_range(1000) + 1) : {$urandom, $urandom};
               ptag[i] = 4'($urandom_range(15));
            end
            req_div[i] = pdiv[i];
            req_a[i*DATA_W +: DATA_W] = pa[i];
            req_b[i*DATA_W +: DATA_W] = pb[i];
            req_tag[i*TAG_W +: TAG_W] = ptag[i];
         end
         req_valid = pend;
         cdb_ready = 1'($urandom_range(1));
         #1;
         exp_rdy = (!m_inflight && cyc >= m_free_at) ? pick(pend, m_ptr) : '0;
         exp_v   = m_inflight && (cyc >= m_valid_at);
         check("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
         check("rnd_cdb_valid", 64'(cdb_valid), 64'(exp_v));
         if (exp_v) begin
            check("rnd_cdb_tag", 64'(cdb_tag), 64'(m_tag));
            check("rnd_cdb_data", cdb_data, m_data);
         end
         if (exp_v && cdb_ready) begin
            m_inflight = 0;
            m_free_at  = cyc + 1;
         end else if (exp_rdy != 0) begin
            gi = onehot_idx(exp_rdy);
            m_inflight = 1;
            m_tag  = ptag[gi];
            m_data = ref_result(pdiv[gi], pa[gi], pb[gi]);
            m_valid_at = cyc + ((pdiv[gi] && pb[gi] == 0) ? 1 :
                                (pdiv[gi] ? DIV_LAT + 1 : MULT_LAT + 1));
            pend[gi] = 1'b0;
            m_ptr = (gi + 1) % NUM_REQ;
         end
         cyc++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
